// File: rtl/stream_packer_if.sv
// Handshake bundle for stream_packer: narrow input stream and wide packed output stream.
// slave is the packer's view; master is the view of whoever drives it.
interface stream_packer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RATIO = 4
);
    logic [WIDTH-1:0]       in_data;
    logic                   in_last;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH*RATIO-1:0] out_data;
    logic [RATIO-1:0]       out_keep;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_data, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_keep, out_last, out_valid
    );

    modport slave (
        input  in_data, in_last, in_valid, out_ready,
        output in_ready, out_data, out_keep, out_last, out_valid
    );
endinterface

// File: rtl/stream_packer.sv
// Width upsizer: packs RATIO narrow words into one wide word with keep mask and last marker.
// Optional idle-flush of partial words is enabled by defining STREAM_PACKER_TIMEOUT_EN.
module stream_packer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned RATIO   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input logic           clk,
    input logic           rst,
    stream_packer_if.slave bus
);
    localparam int unsigned IdxW = $clog2(RATIO);
    localparam int unsigned OutW = WIDTH * RATIO;

    if (RATIO < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("stream_packer: RATIO must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [0:0] {StFill, StHold} state_e;

    state_e           state_q;
    logic [IdxW-1:0]  idx_q;
    logic [OutW-1:0]  data_q;
    logic [RATIO-1:0] keep_q;
    logic             last_q;
    logic             valid_q;

    logic in_xfer;
    logic out_xfer;
    logic lane_end;
    logic timeout_hit;

    assign bus.in_ready  = (state_q == StFill) || bus.out_ready;
    assign in_xfer       = bus.in_valid && bus.in_ready;
    assign out_xfer      = valid_q && bus.out_ready;
    assign lane_end      = (idx_q == IdxW'(RATIO - 1)) || bus.in_last;

    assign bus.out_data  = data_q;
    assign bus.out_keep  = keep_q;
    assign bus.out_last  = last_q;
    assign bus.out_valid = valid_q;

`ifdef STREAM_PACKER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q;

    // Flush fires on the idle cycle that takes the counter to TIMEOUT.
    assign timeout_hit = (state_q == StFill) && !in_xfer && (idx_q != '0) &&
                         (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q != StFill || in_xfer || timeout_hit) begin
            cnt_q <= '0;
        end else if (idx_q != '0) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFill;
            idx_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StFill: begin
                    if (in_xfer) begin
                        data_q[idx_q*WIDTH +: WIDTH] <= bus.in_data;
                        keep_q[idx_q]                <= 1'b1;
                        if (lane_end) begin
                            last_q  <= bus.in_last;
                            idx_q   <= '0;
                            valid_q <= 1'b1;
                            state_q <= StHold;
                        end else begin
                            idx_q <= idx_q + IdxW'(1);
                        end
                    end else if (timeout_hit) begin
                        last_q  <= 1'b0;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (out_xfer) begin
                        if (in_xfer) begin
                            // Word accepted while the held word leaves starts a fresh lane 0.
                            data_q <= OutW'(bus.in_data);
                            keep_q <= RATIO'(1);
                            if (bus.in_last) begin
                                last_q <= 1'b1;
                            end else begin
                                last_q  <= 1'b0;
                                valid_q <= 1'b0;
                                idx_q   <= IdxW'(1);
                                state_q <= StFill;
                            end
                        end else begin
                            data_q  <= '0;
                            keep_q  <= '0;
                            last_q  <= 1'b0;
                            valid_q <= 1'b0;
                            state_q <= StFill;
                        end
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer: directed scenarios plus random traffic,
// scored against a queue-based packing model by a separate output monitor.
module tb_stream_packer;
    localparam int unsigned W = 8;
    localparam int unsigned R = 4;
    localparam int unsigned T = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_packer_if #(.WIDTH(W), .RATIO(R)) bus ();

    stream_packer #(.WIDTH(W), .RATIO(R), .TIMEOUT(T)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic         last;
        logic [R-1:0] keep;
        logic [W*R-1:0] data;
    } beat_t;

    beat_t        exp_q[$];
    logic [W-1:0] acc[$];
    int errors = 0;
    int checks = 0;
    int valid_cycles = 0;
    int stalls = 0;
    bit rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference packer: collect words of a packet, emit a beat per R words or at last.
    function automatic void model_close(input bit last);
        beat_t b;
        b = '0;
        foreach (acc[i]) begin
            b.data[i*W +: W] = acc[i];
            b.keep[i]        = 1'b1;
        end
        b.last = last;
        exp_q.push_back(b);
        acc.delete();
    endfunction

    function automatic void model_word(input logic [W-1:0] d, input bit last);
        acc.push_back(d);
        if (last || acc.size() == R) model_close(last);
    endfunction

    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (bus.out_valid) valid_cycles++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h, expected no output", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_beat", {bus.out_last, bus.out_keep, bus.out_data}, e);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input bit last);
        bit ok;
        int guard;
        guard = 0;
        model_word(d, last);
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            if (!ok) stalls++;
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
            guard++;
        end while (!ok && guard < 1000);
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", guard);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain_empty", 64'(exp_q.size()), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        int n;
        bit seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check("reset_outputs", {bus.out_valid, bus.out_last, bus.out_keep, bus.out_data}, 0);
        check("reset_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full packet ending on the top lane.
        bus.out_ready = 1'b1;
        valid_cycles  = 0;
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
        idle(5);
        check("t1_valid_cycles", 64'(valid_cycles), 1);

        // Short packet.
        send(8'hA1, 0); send(8'hA2, 1);
        idle(3);

        // Continuous stream without last.
        stalls = 0;
        for (int i = 1; i <= 8; i++) send(W'(i), 0);
        idle(3);
        check("t3_no_stall", 64'(stalls), 0);
        check("t3_drained", 64'(exp_q.size()), 0);

        // Back-pressure while holding a full word.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(W'(i), 0);
        bus.in_data  = 8'h55;
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("t4_in_ready_low", bus.in_ready, 0);
            check("t4_hold_data", {bus.out_valid, bus.out_data}, {1'b1, 32'h04030201});
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        model_word(8'h55, 0);
        @(negedge clk);
        check("t4_in_ready_release", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t4_lane0", {bus.out_valid, bus.out_keep, bus.out_data}, {1'b0, 4'b0001, 32'h55});
        @(posedge clk);
        #1;
        send(8'h56, 1);
        idle(3);

        // Asynchronous reset mid-packet.
        send(8'h11, 0); send(8'h22, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_clear", {bus.out_valid, bus.out_keep, bus.out_data}, 0);
        acc.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
        idle(3);

        // Idle partial word.
`ifdef STREAM_PACKER_TIMEOUT_EN
        send(8'h77, 0);
        model_close(0);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_timeout_cycles", 64'(n), T);
        idle(3);
`else
        send(8'h77, 0);
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("t6_no_flush", seen, 0);
        send(8'h78, 1);
        idle(3);
`endif

        // Random traffic with random back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(W'($urandom), $urandom_range(0, 4) == 0);
        end
        send(W'($urandom), 1);
        rand_rdy = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
